cpu_multicycle: RTL



---
 rtl/cpu_multicycle.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/cpu_multicycle.sv
// cpu_multicycle: parametrised FETCH/EXEC/MEM multi-cycle core with handshaked instruction and data memory ports.
// Ports: CLK/RESET (sync, active-high); PC, IMEM_READ, IMEM_BUSYWAIT, INSTRUCTION form the fetch port;
// READ, WRITE, ADDRESS, WRITE_DATA, READ_DATA, BUSYWAIT form the data port (busywait protocol).
// Optional: define CPU_MULTICYCLE_MUL_EN to add opcode 0x0D (iterative shift-add multiply, DATA_W cycles).
module cpu_multicycle #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 8,
    parameter int PC_W   = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic [PC_W-1:0]   PC,
    output logic              IMEM_READ,
    input  logic              IMEM_BUSYWAIT,
    input  logic [31:0]       INSTRUCTION,
    output logic              READ,
    output logic              WRITE,
    output logic [DATA_W-1:0] ADDRESS,
    output logic [DATA_W-1:0] WRITE_DATA,
    input  logic [DATA_W-1:0] READ_DATA,
    input  logic              BUSYWAIT
);
    localparam int RW = $clog2(NREGS);
    typedef enum logic [1:0] {FETCH, EXEC, MEM, MUL} state_t;
    state_t            state;
    logic [31:0]       ir;
    logic [DATA_W-1:0] regs [NREGS];
    logic [7:0]        op;
    logic [RW-1:0]     rd, rs1, rs2;
    logic [DATA_W-1:0] r1, r2, imm, alu, maddr;
    logic [PC_W-1:0]   pc4, target, next_pc;
    logic              is_alu, is_ld, is_mem, take;
    assign op  = ir[31:24];
    assign rd  = ir[16 +: RW];
    // modulo by a power of two keeps only the low index bits of the field
    assign rs1 = RW'(32'(ir[15:8]) % NREGS);
    assign rs2 = ir[0 +: RW];
    assign r1  = regs[rs1];
    assign r2  = regs[rs2];
    assign imm = DATA_W'($signed(ir[7:0]));
    assign pc4     = PC + PC_W'(4);
    assign target  = pc4 + (PC_W'($signed(ir[23:16])) << 2);
    assign is_alu  = op <= 8'h05;
    assign is_ld   = op == 8'h09 || op == 8'h0A;
    assign is_mem  = op >= 8'h09 && op <= 8'h0C;
    assign take    = op == 8'h06 || (op == 8'h07 && r1 == r2) || (op == 8'h08 && r1 != r2);
    assign next_pc = take ? target : pc4;
    assign maddr   = (op == 8'h09 || op == 8'h0B) ? r2 : imm;
    always_comb begin
        alu = op == 8'h00 ? imm :
              op == 8'h01 ? r2 :
              op == 8'h02 ? r1 + r2 :
              op == 8'h03 ? r1 - r2 :
              op == 8'h04 ? r1 & r2 : r1 | r2;
    end
`ifdef CPU_MULTICYCLE_MUL_EN
    localparam int CW = $clog2(DATA_W + 1);
    logic [DATA_W-1:0] acc, mcand, mplier, mul_step;
    logic [CW-1:0]     cnt;
    assign mul_step = acc + (mplier[0] ? mcand : '0);
`endif
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= FETCH;
            PC         <= '0;
            IMEM_READ  <= 1'b0;
            READ       <= 1'b0;
            WRITE      <= 1'b0;
            ADDRESS    <= '0;
            WRITE_DATA <= '0;
            ir         <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
`ifdef CPU_MULTICYCLE_MUL_EN
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
`endif
        end else begin
            case (state)
                FETCH: begin
                    // the request is registered, so the first cycle after reset only raises it
                    if (IMEM_READ && !IMEM_BUSYWAIT) begin
                        ir        <= INSTRUCTION;
                        IMEM_READ <= 1'b0;
                        state     <= EXEC;
                    end else begin
                        IMEM_READ <= 1'b1;
                    end
                end
                EXEC: begin
                    if (is_mem) begin
                        ADDRESS    <= maddr;
                        WRITE_DATA <= r1;
                        READ       <= is_ld;
                        WRITE      <= !is_ld;
                        state      <= MEM;
                    end
`ifdef CPU_MULTICYCLE_MUL_EN
                    else if (op == 8'h0D) begin
                        acc    <= '0;
                        mcand  <= r1;
                        mplier <= r2;
                        cnt    <= '0;
                        state  <= MUL;
                    end
`endif
                    else begin
                        if (is_alu) regs[rd] <= alu;
                        PC        <= next_pc;
                        IMEM_READ <= 1'b1;
                        state     <= FETCH;
                    end
                end
                MEM: begin
                    if (!BUSYWAIT) begin
                        if (READ) regs[rd] <= READ_DATA;
                        READ      <= 1'b0;
                        WRITE     <= 1'b0;
                        PC        <= pc4;
                        IMEM_READ <= 1'b1;
                        state     <= FETCH;
                    end
                end
                default: begin
`ifdef CPU_MULTICYCLE_MUL_EN
                    acc    <= mul_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(DATA_W - 1)) begin
                        regs[rd]  <= mul_step;
                        PC        <= pc4;
                        IMEM_READ <= 1'b1;
                        state     <= FETCH;
                    end
`else
                    state <= FETCH;
`endif
                end
            endcase
        end
    end
endmodule
